ps2_scan_sequencer: RTL and testbench

Sequences the raw byte stream from the PS/2 byte receiver into complete key events. It parses the make, break (F0) and extended (E0) prefixes, discards keyboard system bytes, and enforces an inter-byte timeout. Decoded events are buffered in a small first-word-fall-through FIFO for the consumer. It sits between the byte receiver and the key consumer logic, and drives a clock-inhibit request back to the PS/2 pins when the FIFO is full.

---
 rtl/ps2_scan_sequencer.sv | 254 +++++++++++++++++++++++++
 tb/tb_ps2_scan_sequencer.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_sequencer.sv
// ---------------------------------------------------------------------------
// ps2_scan_sequencer
//
// Turns the raw byte stream from a PS/2 byte receiver into complete key
// events {ext, brk, code}. The E0 (extended) and F0 (break) prefixes are
// folded into the event. Keyboard system bytes (00, AA, EE, FA, FC, FE, FF)
// seen between sequences are dropped. A sequence whose bytes are spaced more
// than TIMEOUT_CYC cycles apart is abandoned. Events queue in a
// first-word-fall-through FIFO. When that FIFO is full, ps2_inhibit asks the
// top level to hold the PS/2 clock low.
//
// Optional feature (compile-time macro TYPEMATIC_FILTER_EN):
//   When the macro is defined, a make code that repeats the most recently
//   pushed make is suppressed until a matching break arrives. This removes
//   keyboard auto-repeat. When the macro is undefined, every make code is
//   queued.
//
// Parameters:
//   FIFO_DEPTH   event entries; a power of 2, at least 2
//   TIMEOUT_CYC  maximum CLK cycles allowed between bytes of one sequence
//
// Ports:
//   CLK           system clock; all logic runs on its rising edge
//   RST           synchronous reset, active low
//   rx_byte       received byte; valid only while rx_done_tick = 1
//   rx_done_tick  one-cycle strobe marking rx_byte as valid
//   key_code      scan code of the FIFO head (0 while empty)
//   key_ext       head event carried the E0 prefix
//   key_brk       head event is a key release
//   key_valid     FIFO holds at least one event
//   key_ack       pops the head; has an effect only while key_valid = 1
//   ps2_inhibit   registered FIFO-full flag; drives the PS/2 clock inhibit
//   seq_err       one-cycle pulse on a timeout or a malformed prefix sequence
//   overflow      sticky; set when an event is dropped, cleared only by reset
// ---------------------------------------------------------------------------
module ps2_scan_sequencer #(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] rx_byte,
  input  logic       rx_done_tick,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_brk,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       ps2_inhibit,
  output logic       seq_err,
  output logic       overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_E0   = 2'd1,
    GOT_F0   = 2'd2,
    GOT_E0F0 = 2'd3
  } state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } event_t;

  // -------------------------------------------------------------------------
  // Byte classification
  // -------------------------------------------------------------------------
  logic is_e0;
  logic is_f0;
  logic is_prefix;
  logic is_system;

  assign is_e0     = (rx_byte == 8'hE0);
  assign is_f0     = (rx_byte == 8'hF0);
  assign is_prefix = is_e0 | is_f0;
  assign is_system = rx_byte inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};

  // -------------------------------------------------------------------------
  // Parser FSM and inter-byte timer
  // -------------------------------------------------------------------------
  state_t        state;
  state_t        state_next;
  logic [TW-1:0] timer;
  logic          timeout;
  logic          parse_push;
  event_t        parse_ev;
  logic          parse_err;

  // A byte that arrives on the last allowed cycle takes priority over the
  // timeout, so the timeout fires only on a cycle that has no tick.
  assign timeout = (state != IDLE) && !rx_done_tick && (timer == TIMER_LAST);

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_next;
      if (rx_done_tick || (state == IDLE) || timeout) timer <= '0;
      else                                            timer <= timer + TW'(1);
    end
  end

  // NOTE: every combinational output gets a default value before any branch,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    if (rx_done_tick) begin
      unique case (state)
        IDLE: begin
          if (is_e0)      state_next = GOT_E0;
          else if (is_f0) state_next = GOT_F0;
        end
        GOT_E0: begin
          if (is_f0)       state_next = GOT_E0F0;
          else if (!is_e0) state_next = IDLE;
        end
        GOT_F0, GOT_E0F0: state_next = IDLE;
        default:          state_next = IDLE;
      endcase
    end else if (timeout) begin
      state_next = IDLE;
    end
  end

  always_comb begin
    parse_push = 1'b0;
    parse_ev   = '{ext: 1'b0, brk: 1'b0, code: rx_byte};
    parse_err  = timeout;
    if (rx_done_tick) begin
      unique case (state)
        IDLE: parse_push = !is_prefix && !is_system;
        GOT_E0: begin
          parse_push   = !is_prefix;
          parse_ev.ext = 1'b1;
        end
        GOT_F0: begin
          parse_push   = !is_prefix;
          parse_err    = is_prefix;
          parse_ev.brk = 1'b1;
        end
        GOT_E0F0: begin
          parse_push   = !is_prefix;
          parse_err    = is_prefix;
          parse_ev.ext = 1'b1;
          parse_ev.brk = 1'b1;
        end
        default: parse_push = 1'b0;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Auto-repeat filter (optional)
  // -------------------------------------------------------------------------
  logic push;

`ifdef TYPEMATIC_FILTER_EN
  logic       held;
  logic [8:0] held_key;
  logic       same_key;

  assign same_key = held && (held_key == {parse_ev.ext, parse_ev.code});
  assign push     = parse_push && !(same_key && !parse_ev.brk);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      held     <= 1'b0;
      held_key <= '0;
    end else if (parse_push) begin
      if (!parse_ev.brk) begin
        // A repeated make rewrites the same value, so the register needs
        // no special case for it.
        held     <= 1'b1;
        held_key <= {parse_ev.ext, parse_ev.code};
      end else if (same_key) begin
        held <= 1'b0;
      end
    end
  end
`else
  assign push = parse_push;
`endif

  // -------------------------------------------------------------------------
  // Event FIFO (first-word fall-through)
  // -------------------------------------------------------------------------
  event_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          full;
  logic          pop;
  logic          wr_en;
  event_t        head;

  assign full  = (count == FULL_COUNT);
  assign pop   = key_valid && key_ack;
  // A full FIFO can still accept a push when it pops on the same cycle.
  assign wr_en = push && (!full || pop);

  always_comb begin
    count_next = count;
    unique case ({wr_en, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // NOTE: the storage array has no reset. The pointers and the count alone
  // decide which entries are valid, so the array can map onto plain RAM.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= parse_ev;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ps2_inhibit <= 1'b0;
      seq_err     <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      count       <= count_next;
      ps2_inhibit <= (count_next == FULL_COUNT);
      seq_err     <= parse_err;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  // The head fields are forced to zero while the FIFO is empty, so the
  // outputs are defined even when they read storage that was never written.
  assign head      = mem[rd_ptr];
  assign key_valid = (count != '0);
  assign key_code  = key_valid ? head.code : 8'h00;
  assign key_ext   = key_valid & head.ext;
  assign key_brk   = key_valid & head.brk;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ps2_scan_sequencer
//
// Self-checking bench for ps2_scan_sequencer. A short TIMEOUT_CYC keeps the
// timeout scenarios brief. Every cycle goes through step(). step() drives
// the inputs on the falling edge and advances a reference model. The model
// is an event queue plus a pair of prefix flags and a last-byte timestamp.
// Just after the rising edge, step() compares all outputs with the model.
// The scenario tasks add their own checks against literal values.
// The bench honours TYPEMATIC_FILTER_EN exactly as the design does.
// ---------------------------------------------------------------------------
module tb_ps2_scan_sequencer;

  localparam int DEPTH = 8;
  localparam int TOUT  = 40;

  logic       CLK          = 1'b0;
  logic       RST          = 1'b0;
  logic [7:0] rx_byte      = 8'h00;
  logic       rx_done_tick = 1'b0;
  logic       key_ack      = 1'b0;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_brk;
  logic       key_valid;
  logic       ps2_inhibit;
  logic       seq_err;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  ps2_scan_sequencer #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TOUT)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .rx_byte      (rx_byte),
    .rx_done_tick (rx_done_tick),
    .key_code     (key_code),
    .key_ext      (key_ext),
    .key_brk      (key_brk),
    .key_valid    (key_valid),
    .key_ack      (key_ack),
    .ps2_inhibit  (ps2_inhibit),
    .seq_err      (seq_err),
    .overflow     (overflow)
  );

  always #5 CLK = ~CLK;

  // Reference model state. Each queue entry is {ext, brk, code}.
  logic [9:0] mq[$];
  bit         m_ext      = 1'b0;
  bit         m_brk      = 1'b0;
  bit         m_ovf      = 1'b0;
  bit         m_held     = 1'b0;
  logic [8:0] m_held_key = '0;
  bit         m_err      = 1'b0;
  int         m_cycle    = 0;
  int         m_last     = 0;
  int         err_seen   = 0;

  function automatic bit is_sys(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
  endfunction

  // One clock cycle: drive, update the model, compare.
  task automatic step(input bit tick, input logic [7:0] b, input bit ack, input bit rst_n);
    bit         p;
    bit         drop;
    bit         pop;
    logic [9:0] ev;
    bit         exp_valid;
    p    = 1'b0;
    drop = 1'b0;
    ev   = '0;
    @(negedge CLK);
    RST          = rst_n;
    rx_done_tick = tick;
    rx_byte      = tick ? b : 8'($urandom);
    key_ack      = ack;
    m_err        = 1'b0;
    if (!rst_n) begin
      mq.delete();
      m_ext  = 1'b0;
      m_brk  = 1'b0;
      m_ovf  = 1'b0;
      m_held = 1'b0;
      m_last = m_cycle;
    end else begin
      pop = (mq.size() != 0) && ack;
      if (tick) begin
        m_last = m_cycle;
        if (!m_ext && !m_brk) begin
          if (b == 8'hE0)      m_ext = 1'b1;
          else if (b == 8'hF0) m_brk = 1'b1;
          else if (!is_sys(b)) begin p = 1'b1; ev = {2'b00, b}; end
        end else if (m_ext && !m_brk) begin
          if (b == 8'hF0)      m_brk = 1'b1;
          else if (b != 8'hE0) begin p = 1'b1; ev = {2'b10, b}; m_ext = 1'b0; end
        end else begin
          if (b == 8'hE0 || b == 8'hF0) m_err = 1'b1;
          else begin p = 1'b1; ev = {m_ext, 1'b1, b}; end
          m_ext = 1'b0;
          m_brk = 1'b0;
        end
      end else if ((m_ext || m_brk) && (m_cycle - m_last == TOUT)) begin
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_err = 1'b1;
      end
`ifdef TYPEMATIC_FILTER_EN
      if (p) begin
        if (!ev[8]) begin
          if (m_held && m_held_key == {ev[9], ev[7:0]}) drop = 1'b1;
          m_held     = 1'b1;
          m_held_key = {ev[9], ev[7:0]};
        end else if (m_held && m_held_key == {ev[9], ev[7:0]}) begin
          m_held = 1'b0;
        end
      end
`endif
      if (p && !drop && mq.size() == DEPTH && !pop) m_ovf = 1'b1;
      else begin
        if (pop) void'(mq.pop_front());
        if (p && !drop) mq.push_back(ev);
      end
    end
    m_cycle++;
    @(posedge CLK);
    #1;
    if (seq_err === 1'b1) err_seen++;
    exp_valid = (mq.size() != 0);
    checks++;
    if (key_valid !== exp_valid) begin
      failures++;
      $display("FAIL key_valid cyc=%0d: got %b expected %b", m_cycle, key_valid, exp_valid);
    end
    if (exp_valid) begin
      checks++;
      if ({key_ext, key_brk, key_code} !== mq[0]) begin
        failures++;
        $display("FAIL head cyc=%0d: got %h expected %h", m_cycle, {key_ext, key_brk, key_code}, mq[0]);
      end
    end
    checks++;
    if (ps2_inhibit !== (mq.size() == DEPTH)) begin
      failures++;
      $display("FAIL ps2_inhibit cyc=%0d: got %b expected %b", m_cycle, ps2_inhibit, mq.size() == DEPTH);
    end
    checks++;
    if (seq_err !== m_err) begin
      failures++;
      $display("FAIL seq_err cyc=%0d: got %b expected %b", m_cycle, seq_err, m_err);
    end
    checks++;
    if (overflow !== m_ovf) begin
      failures++;
      $display("FAIL overflow cyc=%0d: got %b expected %b", m_cycle, overflow, m_ovf);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h1C, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  // Pops until empty, with a bounded number of cycles, and returns the pop count.
  task automatic drain(output int n);
    n = 0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      if (key_valid !== 1'b1) break;
      step(1'b0, 8'h00, 1'b1, 1'b1);
      n++;
    end
    checks++;
    if (key_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain: key_valid=%b after %0d pops, expected 0", key_valid, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({key_code, key_ext, key_brk, key_valid, ps2_inhibit, seq_err, overflow} !== 14'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0",
               {key_code, key_ext, key_brk, key_valid, ps2_inhibit, seq_err, overflow});
    end
  endtask

  task automatic test_make_break();
    int n;
    step(1'b1, 8'h1C, 1'b0, 1'b1);
    checks++;
    if ({key_valid, key_ext, key_brk, key_code} !== {3'b100, 8'h1C}) begin
      failures++;
      $display("FAIL make_1c: got %h expected %h", {key_valid, key_ext, key_brk, key_code}, {3'b100, 8'h1C});
    end
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b1, 8'hF0, 1'b0, 1'b1);
    checks++;
    if (key_valid !== 1'b0) begin
      failures++;
      $display("FAIL prefix_no_event: key_valid got %b expected 0", key_valid);
    end
    step(1'b1, 8'h1C, 1'b0, 1'b1);
    checks++;
    if ({key_valid, key_ext, key_brk, key_code} !== {3'b101, 8'h1C}) begin
      failures++;
      $display("FAIL break_1c: got %h expected %h", {key_valid, key_ext, key_brk, key_code}, {3'b101, 8'h1C});
    end
    drain(n);
  endtask

  task automatic test_extended();
    int n;
    int e0;
    e0 = err_seen;
    step(1'b1, 8'hE0, 1'b0, 1'b1);
    step(1'b1, 8'h75, 1'b0, 1'b1);
    step(1'b1, 8'hE0, 1'b0, 1'b1);
    step(1'b1, 8'hF0, 1'b0, 1'b1);
    step(1'b1, 8'h75, 1'b0, 1'b1);
    checks++;
    if ({key_valid, key_ext, key_brk, key_code} !== {3'b110, 8'h75}) begin
      failures++;
      $display("FAIL ext_make: got %h expected %h", {key_valid, key_ext, key_brk, key_code}, {3'b110, 8'h75});
    end
    step(1'b0, 8'h00, 1'b1, 1'b1);
    checks++;
    if ({key_valid, key_ext, key_brk, key_code} !== {3'b111, 8'h75}) begin
      failures++;
      $display("FAIL ext_break: got %h expected %h", {key_valid, key_ext, key_brk, key_code}, {3'b111, 8'h75});
    end
    checks++;
    if (err_seen != e0) begin
      failures++;
      $display("FAIL ext_no_err: seq_err pulses got %0d expected 0", err_seen - e0);
    end
    drain(n);
  endtask

  task automatic test_system();
    step(1'b1, 8'hAA, 1'b0, 1'b1);
    step(1'b1, 8'hFA, 1'b0, 1'b1);
    step(1'b1, 8'h1C, 1'b0, 1'b1);
    // The key must decode as a plain make, which shows the parser stayed in IDLE.
    checks++;
    if ({key_valid, key_ext, key_brk, key_code} !== {3'b100, 8'h1C}) begin
      failures++;
      $display("FAIL system_discard: got %h expected %h", {key_valid, key_ext, key_brk, key_code}, {3'b100, 8'h1C});
    end
    step(1'b0, 8'h00, 1'b1, 1'b1);
    checks++;
    if (key_valid !== 1'b0) begin
      failures++;
      $display("FAIL system_empty: key_valid got %b expected 0", key_valid);
    end
  endtask

  task automatic test_timeout();
    int n;
    int e0;
    e0 = err_seen;
    step(1'b1, 8'hE0, 1'b0, 1'b1);
    idle(TOUT);
    step(1'b1, 8'h1C, 1'b0, 1'b1);
    checks++;
    if (err_seen - e0 != 1) begin
      failures++;
      $display("FAIL timeout_err: seq_err pulses got %0d expected 1", err_seen - e0);
    end
    checks++;
    if ({key_valid, key_ext, key_brk, key_code} !== {3'b100, 8'h1C}) begin
      failures++;
      $display("FAIL timeout_event: got %h expected %h", {key_valid, key_ext, key_brk, key_code}, {3'b100, 8'h1C});
    end
    drain(n);
    e0 = err_seen;
    step(1'b1, 8'hE0, 1'b0, 1'b1);
    idle(TOUT - 1);
    step(1'b1, 8'h1C, 1'b0, 1'b1);
    checks++;
    if (err_seen != e0) begin
      failures++;
      $display("FAIL edge_no_err: seq_err pulses got %0d expected 0", err_seen - e0);
    end
    checks++;
    if ({key_valid, key_ext, key_brk, key_code} !== {3'b110, 8'h1C}) begin
      failures++;
      $display("FAIL edge_event: got %h expected %h", {key_valid, key_ext, key_brk, key_code}, {3'b110, 8'h1C});
    end
    drain(n);
  endtask

  task automatic test_fifo_full();
    int n;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 8'(8'h15 + i), 1'b0, 1'b1);
      if (i == 6) begin
        checks++;
        if (ps2_inhibit !== 1'b0) begin
          failures++;
          $display("FAIL inhibit_7: got %b expected 0", ps2_inhibit);
        end
      end
      if (i == 7) begin
        checks++;
        if ({ps2_inhibit, overflow} !== 2'b10) begin
          failures++;
          $display("FAIL inhibit_8: got %b expected 10", {ps2_inhibit, overflow});
        end
      end
    end
    checks++;
    if ({overflow, key_code} !== {1'b1, 8'h15}) begin
      failures++;
      $display("FAIL overflow_9: got %h expected %h", {overflow, key_code}, {1'b1, 8'h15});
    end
    step(1'b0, 8'h00, 1'b1, 1'b1);
    checks++;
    if ({ps2_inhibit, key_code} !== {1'b0, 8'h16}) begin
      failures++;
      $display("FAIL pop_release: got %h expected %h", {ps2_inhibit, key_code}, {1'b0, 8'h16});
    end
    step(1'b1, 8'h1E, 1'b0, 1'b1);
    step(1'b1, 8'h1F, 1'b1, 1'b1);
    checks++;
    if ({ps2_inhibit, overflow, key_code} !== {2'b11, 8'h17}) begin
      failures++;
      $display("FAIL full_push_pop: got %h expected %h", {ps2_inhibit, overflow, key_code}, {2'b11, 8'h17});
    end
    drain(n);
    checks++;
    if (n != DEPTH) begin
      failures++;
      $display("FAIL full_count: popped %0d expected %0d", n, DEPTH);
    end
  endtask

  task automatic test_reset_abort();
    step(1'b1, 8'h33, 1'b0, 1'b1);
    step(1'b1, 8'hE0, 1'b0, 1'b1);
    step(1'b1, 8'hF0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if ({key_valid, overflow} !== 2'b00) begin
      failures++;
      $display("FAIL abort_clear: got %b expected 00", {key_valid, overflow});
    end
    step(1'b1, 8'h1C, 1'b0, 1'b1);
    checks++;
    if ({key_valid, key_ext, key_brk, key_code} !== {3'b100, 8'h1C}) begin
      failures++;
      $display("FAIL abort_fresh: got %h expected %h", {key_valid, key_ext, key_brk, key_code}, {3'b100, 8'h1C});
    end
    step(1'b0, 8'h00, 1'b1, 1'b1);
  endtask

  task automatic test_typematic();
    logic [7:0] seq [6];
    logic [9:0] want [5];
    int         n_want;
    int         n;
    seq = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
`ifdef TYPEMATIC_FILTER_EN
    n_want = 3;
    want   = '{10'h01C, 10'h11C, 10'h01C, 10'h000, 10'h000};
`else
    n_want = 5;
    want   = '{10'h01C, 10'h01C, 10'h01C, 10'h11C, 10'h01C};
`endif
    do_reset();
    foreach (seq[i]) step(1'b1, seq[i], 1'b0, 1'b1);
    n = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (key_valid !== 1'b1) break;
      if (n < 5) begin
        checks++;
        if ({key_ext, key_brk, key_code} !== want[n]) begin
          failures++;
          $display("FAIL typematic_ev%0d: got %h expected %h", n, {key_ext, key_brk, key_code}, want[n]);
        end
      end
      step(1'b0, 8'h00, 1'b1, 1'b1);
      n++;
    end
    checks++;
    if (n != n_want) begin
      failures++;
      $display("FAIL typematic_count: got %0d events expected %0d", n, n_want);
    end
  endtask

  task automatic test_random();
    logic [7:0] codes [4];
    logic [7:0] sys [7];
    codes = '{8'h1C, 8'h1D, 8'h75, 8'h5A};
    sys   = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
    for (int n = 0; n < 400; n++) begin
      int         sel;
      int         gap;
      logic [7:0] b;
      sel = $urandom_range(0, 9);
      if (sel < 2)       b = 8'hE0;
      else if (sel < 4)  b = 8'hF0;
      else if (sel == 4) b = sys[$urandom_range(0, 6)];
      else if (sel < 8)  b = codes[$urandom_range(0, 3)];
      else               b = 8'($urandom);
      step(1'b1, b, ($urandom_range(0, 2) == 0), 1'b1);
      if ($urandom_range(0, 19) == 0) gap = TOUT - 2 + $urandom_range(0, 3);
      else                            gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step(1'b0, 8'h00, ($urandom_range(0, 2) == 0), 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    for (int i = 0; i < 200; i++)
      step(1'b1, 8'($urandom_range(8'h10, 8'hF2)), ($urandom_range(0, 1) == 1), 1'b1);
    drain(n);
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_system();
    test_timeout();
    test_fifo_full();
    test_reset_abort();
    test_typematic();
    test_random();
    test_back_to_back();
    @(negedge CLK);
    rx_done_tick = 1'b0;
    key_ack      = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
